// File: rtl/sdram_arb_pkg.sv
// sdram_arbiter shared types: FSM states, op kinds, SDRAM widths
// and the registered command bundle driven toward the access core.
package sdram_arb_pkg;

    localparam int SDRAM_AW = 23;
    localparam int SDRAM_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    typedef struct packed {
        logic [SDRAM_AW-1:0] addr;
        logic [SDRAM_DW-1:0] wdata;
        logic                rd;
        logic                wr;
    } sdram_cmd_t;

endpackage

// File: rtl/sdram_arb_if.sv
// sdram_arbiter bus: requester side plus SDRAM access-core side.
// master = arbiter, slave = requesters and access core.
interface sdram_arb_if
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0][SDRAM_AW-1:0] req_addr;
    logic [NUM_REQ-1:0]               req_read;
    logic [NUM_REQ-1:0]               req_write;
    logic [NUM_REQ-1:0][SDRAM_DW-1:0] req_wdata;
    logic [SDRAM_DW-1:0]              req_rdata;
    logic [NUM_REQ-1:0]               req_done;
    logic [NUM_REQ-1:0]               grant;
    logic [SDRAM_AW-1:0]              sdram_addr;
    logic                             sdram_read;
    logic                             sdram_write;
    logic [SDRAM_DW-1:0]              sdram_writedata;
    logic [SDRAM_DW-1:0]              sdram_readdata;
    logic                             sdram_finished;

    modport master (
        input  req_addr, req_read, req_write, req_wdata,
        input  sdram_readdata, sdram_finished,
        output req_rdata, req_done, grant,
        output sdram_addr, sdram_read, sdram_write, sdram_writedata
    );

    modport slave (
        output req_addr, req_read, req_write, req_wdata,
        output sdram_readdata, sdram_finished,
        input  req_rdata, req_done, grant,
        input  sdram_addr, sdram_read, sdram_write, sdram_writedata
    );

endinterface

// File: rtl/sdram_arb_pick.sv
// Rotating one-hot picker: first pending bit at or above start,
// wrapping from N-1 back to 0.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  winner,
    output logic          valid
);

    logic [PW:0] idx;

    // scan N slots from start; the first pending slot wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, start} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!valid && pending[idx[PW-1:0]]) begin
                winner[idx[PW-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM access port between requesters.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sdram_arb_if.master bus
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_t          state, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [SDRAM_DW-1:0] rdata_q, rdata_d;
    sdram_cmd_t          cmd_q, cmd_d;
    logic [3:0]          gap_q, gap_d;
    logic [NUM_REQ-1:0]  pending, pick_oh;
    logic                pick_vld, owner_live;
    logic [PW-1:0]       win_idx, start;
    op_t                 pick_op;

    assign pending    = bus.req_read | bus.req_write;
    assign owner_live = |(grant_q & pending);
    assign pick_op    = |(pick_oh & bus.req_write) ? OP_WRITE : OP_READ;

    sdram_arb_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .pending (pending),
        .start   (start),
        .winner  (pick_oh),
        .valid   (pick_vld)
    );

    // one-hot winner to index for the address/data mux
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) win_idx = PW'(i);
        end
    end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [PW-1:0] rr_ptr;

    assign start = rr_ptr;

    // search pointer moves just past each winner
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr <= '0;
        end else if (state == IDLE && pick_vld) begin
            rr_ptr <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
        end
    end
`endif

    // next state and next registered outputs
    always_comb begin
        state_d = state;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        done_d  = '0;
        rdata_d = rdata_q;
        gap_d   = gap_q;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_d     = pick_oh;
                    cmd_d.addr  = bus.req_addr[win_idx];
                    cmd_d.wdata = bus.req_wdata[win_idx];
                    cmd_d.wr    = (pick_op == OP_WRITE);
                    cmd_d.rd    = (pick_op == OP_READ);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (bus.sdram_finished) begin
                    if (cmd_q.rd) rdata_d = bus.sdram_readdata;
                    done_d   = grant_q;
                    cmd_d.rd = 1'b0;
                    cmd_d.wr = 1'b0;
                    gap_d    = '0;
                    state_d  = GAP;
                end else if (!owner_live) begin
                    cmd_d.rd = 1'b0;
                    cmd_d.wr = 1'b0;
                    gap_d    = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    grant_d = '0;
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and every output toward core and requesters are registered
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            cmd_q   <= '0;
            gap_q   <= '0;
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            cmd_q   <= cmd_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.grant           = grant_q;
    assign bus.req_done        = done_q;
    assign bus.req_rdata       = rdata_q;
    assign bus.sdram_addr      = cmd_q.addr;
    assign bus.sdram_writedata = cmd_q.wdata;
    assign bus.sdram_read      = cmd_q.rd;
    assign bus.sdram_write     = cmd_q.wr;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios followed by
// random traffic, checked against a transaction-level arbitration model.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int N   = 3;
    localparam int GAP = 2;

    logic i_clk = 1'b0;
    logic i_rst;
    int   checks = 0;
    int   errors = 0;

    sdram_arb_if #(.NUM_REQ(N)) bus ();

    sdram_arbiter #(
        .NUM_REQ    (N),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.master)
    );

    always #5 i_clk = ~i_clk;

    logic        m_rd   [N];
    logic        m_wr   [N];
    logic [22:0] m_addr [N];
    logic [31:0] m_wd   [N];
    int          ptr_m;
    logic [31:0] last_rdata;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_read[i]  = m_rd[i];
            bus.req_write[i] = m_wr[i];
            bus.req_addr[i]  = m_addr[i];
            bus.req_wdata[i] = m_wd[i];
        end
    endtask

    // kind: 0 read, 1 write, 2 both
    task automatic new_req(int i, int kind);
        m_addr[i] = 23'($urandom);
        m_wd[i]   = $urandom;
        m_rd[i]   = (kind != 1);
        m_wr[i]   = (kind != 0);
        drive();
    endtask

    // round-robin rule: first pending requester at or after the pointer
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (m_rd[(ptr_m + k) % N] || m_wr[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic check_all_zero(string tag);
        check({tag, "_grant"}, 64'(bus.grant), 64'(0));
        check({tag, "_rd"}, 64'(bus.sdram_read), 64'(0));
        check({tag, "_wr"}, 64'(bus.sdram_write), 64'(0));
        check({tag, "_done"}, 64'(bus.req_done), 64'(0));
        check({tag, "_addr"}, 64'(bus.sdram_addr), 64'(0));
        check({tag, "_wdata"}, 64'(bus.sdram_writedata), 64'(0));
        check({tag, "_rdata"}, 64'(bus.req_rdata), 64'(0));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        check_all_zero("rst");
        step();
        i_rst      = 1'b0;
        ptr_m      = 0;
        last_rdata = '0;
    endtask

    // one transaction: wait for the op, hold it, then finish or abort.
    // Returns two cycles after the finish/drop cycle.
    task automatic run_txn(bit abort, int busy, int exp_lat,
                           logic [31:0] rdv, output int who);
        int w;
        int lat;
        bit is_wr;
        w   = model_pick();
        who = w;
        if (w < 0) return;
        is_wr = m_wr[w];
        lat   = 0;
        while (!(bus.sdram_read || bus.sdram_write) && lat < 50) begin
            step();
            lat++;
        end
        if (!(bus.sdram_read || bus.sdram_write)) begin
            check("op_timeout", 64'(bus.sdram_read | bus.sdram_write), 64'(1));
            return;
        end
        if (exp_lat >= 0) check("latency", 64'(lat), 64'(exp_lat));
        ptr_m = (w + 1) % N;
        check("grant", 64'(bus.grant), 64'(1 << w));
        check("op_wr", 64'(bus.sdram_write), 64'(is_wr));
        check("op_rd", 64'(bus.sdram_read), 64'(!is_wr));
        check("addr", 64'(bus.sdram_addr), 64'(m_addr[w]));
        check("wdata", 64'(bus.sdram_writedata), 64'(m_wd[w]));
        for (int b = 0; b < busy; b++) begin
            step();
            check("hold_op", 64'(bus.sdram_read | bus.sdram_write), 64'(1));
            check("hold_addr", 64'(bus.sdram_addr), 64'(m_addr[w]));
            check("busy_done", 64'(bus.req_done), 64'(0));
        end
        if (abort) begin
            m_rd[w] = 1'b0;
            m_wr[w] = 1'b0;
            drive();
            bus.sdram_readdata = $urandom;
            step();
            check("abort_op", 64'(bus.sdram_read | bus.sdram_write), 64'(0));
            check("abort_done", 64'(bus.req_done), 64'(0));
            check("abort_rdata", 64'(bus.req_rdata), 64'(last_rdata));
            step();
            check("abort_done2", 64'(bus.req_done), 64'(0));
        end else begin
            bus.sdram_readdata = rdv;
            bus.sdram_finished = 1'b1;
            step();
            bus.sdram_finished = 1'b0;
            bus.sdram_readdata = $urandom;
            if (!is_wr) last_rdata = rdv;
            check("done", 64'(bus.req_done), 64'(1 << w));
            check("rdata", 64'(bus.req_rdata), 64'(last_rdata));
            check("op_low", 64'(bus.sdram_read | bus.sdram_write), 64'(0));
            m_rd[w] = 1'b0;
            m_wr[w] = 1'b0;
            drive();
            step();
            check("done_pulse", 64'(bus.req_done), 64'(0));
        end
    endtask

    initial begin
        int who;
        int any;
        i_rst              = 1'b0;
        bus.sdram_finished = 1'b0;
        bus.sdram_readdata = '0;
        for (int i = 0; i < N; i++) begin
            m_rd[i]   = 1'b0;
            m_wr[i]   = 1'b0;
            m_addr[i] = '0;
            m_wd[i]   = '0;
        end
        drive();
        ptr_m      = 0;
        last_rdata = '0;
        #2;
        do_reset();

        // single read of 0x000100 answered with 0xDEADBEEF
        new_req(0, 0);
        m_addr[0] = 23'h000100;
        drive();
        run_txn(1'b0, 3, 1, 32'hDEADBEEF, who);
        check("single_rdata", 64'(bus.req_rdata), 64'(32'hDEADBEEF));

        // three simultaneous writes from a fresh pointer: 0, 1, 2
        do_reset();
        for (int i = 0; i < N; i++) new_req(i, 1);
        run_txn(1'b0, 1, 1, $urandom, who);
        run_txn(1'b0, 2, GAP, $urandom, who);
        run_txn(1'b0, 0, GAP, $urandom, who);

        // R0 re-requests right after its done while R2 waits
        new_req(0, 0);
        new_req(2, 0);
        run_txn(1'b0, 1, GAP, $urandom, who);
        new_req(0, 0);
        run_txn(1'b0, 1, GAP, $urandom, who);
        run_txn(1'b0, 1, GAP, $urandom, who);

        // read and write together on R1
        new_req(1, 2);
        run_txn(1'b0, 2, GAP, $urandom, who);

        // R1 aborts its read; back to idle after the gap
        new_req(1, 0);
        run_txn(1'b1, 2, GAP, $urandom, who);
        for (int i = 0; i < GAP - 1; i++) step();
        check("idle_grant", 64'(bus.grant), 64'(0));
        check("idle_op", 64'(bus.sdram_read | bus.sdram_write), 64'(0));

        // reset in the middle of BUSY with R2 waiting
        new_req(0, 0);
        step();
        check("pre_rst_op", 64'(bus.sdram_read), 64'(1));
        new_req(2, 1);
        m_rd[0] = 1'b0;
        m_wr[0] = 1'b0;
        drive();
        do_reset();
        run_txn(1'b0, 1, 1, $urandom, who);

        // random traffic
        for (int t = 0; t < 25; t++) begin
            any = 0;
            for (int i = 0; i < N; i++) begin
                if (!m_rd[i] && !m_wr[i] && $urandom_range(1, 0) == 1) begin
                    new_req(i, int'($urandom_range(2, 0)));
                end
                if (m_rd[i] || m_wr[i]) any = 1;
            end
            if (any == 0) new_req(int'($urandom_range(N - 1, 0)), 0);
            run_txn($urandom_range(5, 0) == 0, int'($urandom_range(4, 0)),
                    GAP, $urandom, who);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
